// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared types and helpers for the register-file write arbiter
package regfile_arb_pkg;
  typedef enum logic {IDLE, CLEAR} arb_state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over NUM_REQ requesters; owns the search pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = 2
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);
  logic [IW-1:0] ptr;
  logic found;
  int j;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (enable && !found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) ptr <= '0;
    else if (found) ptr <= IW'((int'(grant_idx) + 1) % NUM_REQ);
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin register-file write port sharing; clear sweep under REGFILE_ARB_CLEAR_EN
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          clear_req,
  output logic                          clear_busy,
  output logic                          rf_wr_en,
  output logic [ADDR_WIDTH-1:0]         rf_wr_addr,
  output logic [DATA_WIDTH-1:0]         rf_wr_data,
  output logic [idx_w(NUM_REQ)-1:0]     grant_id
);
  localparam int IW = idx_w(NUM_REQ);
  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } rf_wr_t;
  rf_wr_t wr_q;
  logic [IW-1:0] gidx;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic fire;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk       (clk),
    .arst_n    (arst_n),
    .req       (req_valid),
    .enable    (!clear_busy),
    .grant     (req_ready),
    .grant_idx (gidx)
  );
  assign fire = |(req_valid & req_ready);
`ifdef REGFILE_ARB_CLEAR_EN
  arb_state_e state, state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE && clear_req) state_nxt = CLEAR;
    else if (state == CLEAR && &clr_addr) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= IDLE;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      clr_addr <= state == CLEAR ? clr_addr + 1'b1 : '0;
    end
  assign clear_busy = state == CLEAR;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign clear_busy = 1'b0;
  assign clr_addr = '0;
`endif
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      wr_q <= '0;
      grant_id <= '0;
    end else if (clear_busy) begin
      wr_q <= {1'b1, clr_addr, DATA_WIDTH'(0)};
      grant_id <= '0;
    end else if (fire) begin
      wr_q <= {1'b1, req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH], req_data[gidx*DATA_WIDTH +: DATA_WIDTH]};
      grant_id <= gidx;
    end else
      wr_q.en <= 1'b0;
  assign rf_wr_en = wr_q.en;
  assign rf_wr_addr = wr_q.addr;
  assign rf_wr_data = wr_q.data;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: table-driven check of arbitration and write path, plus clear/reset sequences
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] req_addr = '0;
  logic [127:0] req_data = '0;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [1:0]  grant_id;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] ready;
    logic [1:0] gid;
  } vec_t;
  vec_t tbl[14];
  logic        pen;
  logic [3:0]  paddr;
  logic [31:0] pdata;
  logic [1:0]  pgid;
  regfile_write_arbiter dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .clear_req(clear_req),
    .clear_busy(clear_busy), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_wr(input logic en, input logic [3:0] a, input logic [31:0] d, input logic [1:0] g);
    check("rf_wr_en", 64'(rf_wr_en), 64'(en));
    check("rf_wr_addr", 64'(rf_wr_addr), 64'(a));
    check("rf_wr_data", 64'(rf_wr_data), 64'(d));
    check("grant_id", 64'(grant_id), 64'(g));
  endtask
  task automatic step(input logic [3:0] v, input logic clr);
    @(negedge clk);
    req_valid = v;
    clear_req = clr;
    #1;
  endtask
  initial begin
    tbl[0]  = '{4'b0010, 4'b0010, 2'd1};
    tbl[1]  = '{4'b0010, 4'b0010, 2'd1};
    tbl[2]  = '{4'b0010, 4'b0010, 2'd1};
    tbl[3]  = '{4'b1011, 4'b1000, 2'd3};
    tbl[4]  = '{4'b1111, 4'b0001, 2'd0};
    tbl[5]  = '{4'b1111, 4'b0010, 2'd1};
    tbl[6]  = '{4'b1111, 4'b0100, 2'd2};
    tbl[7]  = '{4'b1111, 4'b1000, 2'd3};
    tbl[8]  = '{4'b1111, 4'b0001, 2'd0};
    tbl[9]  = '{4'b0000, 4'b0000, 2'd0};
    tbl[10] = '{4'b0001, 4'b0001, 2'd0};
    tbl[11] = '{4'b1100, 4'b0100, 2'd2};
    tbl[12] = '{4'b0101, 4'b0001, 2'd0};
    tbl[13] = '{4'b0000, 4'b0000, 2'd0};
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(clear_busy), 64'd0);
    check_wr(1'b0, 4'd0, 32'd0, 2'd0);
    @(negedge clk);
    arst_n = 1'b1;
    req_addr[8 +: 4] = 4'd5;
    req_data[64 +: 32] = 32'hA5A5_A5A5;
    step(4'b0100, 1'b0);
    check("first_ready", 64'(req_ready), 64'b0100);
    step(4'b0000, 1'b0);
    check("first_ready_off", 64'(req_ready), 64'd0);
    check_wr(1'b1, 4'd5, 32'hA5A5_A5A5, 2'd2);
    pen = 1'b0; paddr = 4'd5; pdata = 32'hA5A5_A5A5; pgid = 2'd2;
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      req_valid = tbl[v].valid;
      for (int i = 0; i < 4; i++) begin
        req_addr[i*4 +: 4] = 4'((i*3 + v) & 15);
        req_data[i*32 +: 32] = 32'hA000_0000 | 32'(v << 8) | 32'(i);
      end
      #1;
      check("tbl_ready", 64'(req_ready), 64'(tbl[v].ready));
      check_wr(pen, paddr, pdata, pgid);
      pen = tbl[v].ready != 4'd0;
      if (pen) begin
        pgid = tbl[v].gid;
        paddr = 4'((int'(pgid)*3 + v) & 15);
        pdata = 32'hA000_0000 | 32'(v << 8) | 32'(pgid);
      end
    end
    step(4'b0000, 1'b0);
    check_wr(pen, paddr, pdata, pgid);
`ifdef REGFILE_ARB_CLEAR_EN
    req_addr[0 +: 4] = 4'd7;
    req_data[0 +: 32] = 32'h1234_5678;
    step(4'b0001, 1'b1);
    check("clr_same_ready", 64'(req_ready), 64'b0001);
    check("clr_busy_n", 64'(clear_busy), 64'd0);
    req_addr[0 +: 4] = 4'd9;
    req_data[0 +: 32] = 32'h0000_9999;
    step(4'b0001, 1'b0);
    check("clr_busy_n1", 64'(clear_busy), 64'd1);
    check("clr_hold_ready", 64'(req_ready), 64'd0);
    check_wr(1'b1, 4'd7, 32'h1234_5678, 2'd0);
    for (int k = 2; k <= 17; k++) begin
      step(4'b0001, 1'b0);
      check("clr_busy", 64'(clear_busy), 64'(k <= 16));
      check("clr_ready", 64'(req_ready), k <= 16 ? 64'd0 : 64'b0001);
      check_wr(1'b1, 4'(k - 2), 32'd0, 2'd0);
    end
    step(4'b0000, 1'b0);
    check_wr(1'b1, 4'd9, 32'h0000_9999, 2'd0);
    step(4'b0000, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(4'b0000, 1'b0);
      check("abort_busy_pre", 64'(clear_busy), 64'd1);
    end
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("abort_busy", 64'(clear_busy), 64'd0);
    check_wr(1'b0, 4'd0, 32'd0, 2'd0);
    @(negedge clk);
    arst_n = 1'b1;
    req_addr[4 +: 4] = 4'd3;
    req_data[32 +: 32] = 32'h0000_0055;
    step(4'b0010, 1'b0);
    check("post_abort_ready", 64'(req_ready), 64'b0010);
    check("post_abort_busy", 64'(clear_busy), 64'd0);
    step(4'b0000, 1'b0);
    check_wr(1'b1, 4'd3, 32'h0000_0055, 2'd1);
`else
    req_addr[8 +: 4] = 4'd6;
    req_data[64 +: 32] = 32'h0000_0077;
    step(4'b0100, 1'b1);
    check("noclr_ready", 64'(req_ready), 64'b0100);
    check("noclr_busy0", 64'(clear_busy), 64'd0);
    step(4'b0000, 1'b0);
    check("noclr_busy1", 64'(clear_busy), 64'd0);
    check_wr(1'b1, 4'd6, 32'h0000_0077, 2'd2);
    step(4'b0000, 1'b0);
    check("noclr_busy2", 64'(clear_busy), 64'd0);
    check("noclr_idle_en", 64'(rf_wr_en), 64'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
